// File: rtl/store_sb_pkg.sv
// Shared types and helpers for the store scoreboard: the buffered store
// transaction and a saturating counter increment.
package store_sb_pkg;
  localparam int SB_ADDR_W = 10;
  localparam int SB_DATA_W = 32;
  localparam int SB_CNT_W  = 16;

  typedef struct packed {
    logic [SB_ADDR_W-1:0] addr;
    logic [SB_DATA_W-1:0] data;
  } store_txn_t;

  function automatic logic [SB_CNT_W-1:0] sat_inc(input logic [SB_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/txn_fifo.sv
// Synchronous FIFO of store transactions. A push while full is accepted
// only when a pop frees the head slot in the same cycle.
module txn_fifo
  import store_sb_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       CLEAR,
  input  logic       push,
  input  logic       pop,
  input  store_txn_t din,
  output store_txn_t head,
  output logic       full,
  output logic       empty,
  output logic [AW:0] level
);
  store_txn_t      r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [AW:0]     r_cnt;
  logic            w_push, w_pop;

  assign full   = (r_cnt == (AW+1)'(DEPTH));
  assign empty  = (r_cnt == '0);
  assign level  = r_cnt;
  assign head   = r_mem[r_rd_ptr];
  assign w_pop  = pop && !empty;
  assign w_push = push && (!full || w_pop);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else if (CLEAR) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge CLK) begin
    if (w_push && !CLEAR) r_mem[r_wr_ptr] <= din;
  end
endmodule

// File: rtl/store_scoreboard.sv
// In-order store checker: buffers golden stores and compares each DUV store
// against the oldest one, tracking counts, sticky errors and the first failure.
module store_scoreboard
  import store_sb_pkg::*;
#(
  parameter int DATA_WIDTH = SB_DATA_W,
  parameter int ADDR_WIDTH = SB_ADDR_W,
  parameter int DEPTH      = 16,
  parameter int CNT_WIDTH  = SB_CNT_W
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    CLEAR,
  input  logic                    g_we,
  input  logic [ADDR_WIDTH-1:0]   g_addr,
  input  logic [DATA_WIDTH-1:0]   g_data,
  input  logic                    d_we,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [DATA_WIDTH-1:0]   d_data,
  output logic [$clog2(DEPTH):0]  level,
  output logic [CNT_WIDTH-1:0]    match_cnt,
  output logic [CNT_WIDTH-1:0]    mismatch_cnt,
  output logic                    mismatch,
  output logic                    error,
  output logic                    overflow,
  output logic                    unexpected,
  output logic [ADDR_WIDTH-1:0]   fail_exp_addr,
  output logic [DATA_WIDTH-1:0]   fail_exp_data,
  output logic [ADDR_WIDTH-1:0]   fail_got_addr,
  output logic [DATA_WIDTH-1:0]   fail_got_data,
  output logic                    drained
);
  store_txn_t w_g_txn, w_d_txn, w_head, w_exp;
  logic w_full, w_empty, w_pop, w_push, w_bypass, w_cmp, w_mm, w_ovf, w_unx, w_fail;

  logic [CNT_WIDTH-1:0] r_match_cnt, r_mismatch_cnt;
  logic r_mismatch, r_error, r_overflow, r_unexpected;
  store_txn_t r_fail_exp, r_fail_got;

  assign w_g_txn = '{addr: g_addr, data: g_data};
  assign w_d_txn = '{addr: d_addr, data: d_data};

  assign w_pop    = d_we && !w_empty;
  assign w_bypass = d_we && g_we && w_empty;
  assign w_push   = g_we && !w_bypass;

  // With an empty FIFO the incoming golden store is the expected one.
  assign w_cmp  = d_we && (!w_empty || g_we);
  assign w_exp  = w_empty ? w_g_txn : w_head;
  assign w_mm   = w_cmp && (w_exp != w_d_txn);
  assign w_ovf  = g_we && w_full && !d_we;
  assign w_unx  = d_we && w_empty && !g_we;
  assign w_fail = w_mm || w_ovf || w_unx;

  txn_fifo #(.DEPTH(DEPTH)) u_fifo (
    .CLK   (CLK),
    .RESET (RESET),
    .CLEAR (CLEAR),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_g_txn),
    .head  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .level (level)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_match_cnt    <= '0;
      r_mismatch_cnt <= '0;
      r_mismatch     <= 1'b0;
      r_error        <= 1'b0;
      r_overflow     <= 1'b0;
      r_unexpected   <= 1'b0;
      r_fail_exp     <= '0;
      r_fail_got     <= '0;
    end else if (CLEAR) begin
      r_match_cnt    <= '0;
      r_mismatch_cnt <= '0;
      r_mismatch     <= 1'b0;
      r_error        <= 1'b0;
      r_overflow     <= 1'b0;
      r_unexpected   <= 1'b0;
      r_fail_exp     <= '0;
      r_fail_got     <= '0;
    end else begin
      r_mismatch <= w_mm;
      if (w_cmp && !w_mm) r_match_cnt    <= sat_inc(r_match_cnt);
      if (w_mm)           r_mismatch_cnt <= sat_inc(r_mismatch_cnt);
      if (w_ovf)          r_overflow     <= 1'b1;
      if (w_unx)          r_unexpected   <= 1'b1;
      if (w_fail)         r_error        <= 1'b1;
      // Only the first failure is kept; overflow has no DUV side to record.
      if (w_fail && !r_error) begin
        r_fail_exp <= w_unx ? '0 : (w_ovf ? w_g_txn : w_exp);
        r_fail_got <= w_ovf ? '0 : w_d_txn;
      end
    end
  end

  assign match_cnt     = r_match_cnt;
  assign mismatch_cnt  = r_mismatch_cnt;
  assign mismatch      = r_mismatch;
  assign error         = r_error;
  assign overflow      = r_overflow;
  assign unexpected    = r_unexpected;
  assign fail_exp_addr = r_fail_exp.addr;
  assign fail_exp_data = r_fail_exp.data;
  assign fail_got_addr = r_fail_got.addr;
  assign fail_got_data = r_fail_got.data;
  assign drained       = (level == '0) && !r_error;
endmodule

// File: tb/tb_store_scoreboard.sv
// Bench for store_scoreboard: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a queue-based model.
module tb_store_scoreboard;
  import store_sb_pkg::*;
  localparam int DEPTH = 16;

  logic CLK = 1'b0, RESET = 1'b1, CLEAR = 1'b0;
  logic g_we = 1'b0, d_we = 1'b0;
  logic [9:0]  g_addr = '0, d_addr = '0;
  logic [31:0] g_data = '0, d_data = '0;
  logic [4:0]  level;
  logic [15:0] match_cnt, mismatch_cnt;
  logic mismatch, error, overflow, unexpected, drained;
  logic [9:0]  fail_exp_addr, fail_got_addr;
  logic [31:0] fail_exp_data, fail_got_data;

  store_scoreboard #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .DEPTH(DEPTH), .CNT_WIDTH(16)) dut (
    .CLK(CLK), .RESET(RESET), .CLEAR(CLEAR),
    .g_we(g_we), .g_addr(g_addr), .g_data(g_data),
    .d_we(d_we), .d_addr(d_addr), .d_data(d_data),
    .level(level), .match_cnt(match_cnt), .mismatch_cnt(mismatch_cnt),
    .mismatch(mismatch), .error(error), .overflow(overflow), .unexpected(unexpected),
    .fail_exp_addr(fail_exp_addr), .fail_exp_data(fail_exp_data),
    .fail_got_addr(fail_got_addr), .fail_got_data(fail_got_data),
    .drained(drained)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0, n_fail = 0;
  bit chk_en = 1'b0;

  // Reference model: a plain queue of outstanding golden stores.
  store_txn_t m_q[$];
  int         m_mc, m_mmc;
  bit         m_mm, m_err, m_ovf, m_unx;
  store_txn_t m_fexp, m_fgot;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_q.delete();
    m_mc = 0; m_mmc = 0;
    m_mm = 0; m_err = 0; m_ovf = 0; m_unx = 0;
    m_fexp = '0; m_fgot = '0;
  endfunction

  function automatic void model_fail(input store_txn_t e, input store_txn_t g);
    if (!m_err) begin
      m_fexp = e;
      m_fgot = g;
    end
    m_err = 1;
  endfunction

  function automatic void model_cmp(input store_txn_t e, input store_txn_t g);
    if (e == g) begin
      if (m_mc < 65535) m_mc++;
    end else begin
      if (m_mmc < 65535) m_mmc++;
      m_mm = 1;
      model_fail(e, g);
    end
  endfunction

  function automatic void model_update();
    store_txn_t gt, dt, e;
    gt = '{addr: g_addr, data: g_data};
    dt = '{addr: d_addr, data: d_data};
    if (CLEAR) begin
      model_reset();
      return;
    end
    m_mm = 0;
    if (d_we) begin
      if (m_q.size() > 0) begin
        e = m_q.pop_front();
        model_cmp(e, dt);
        if (g_we) m_q.push_back(gt);
      end else if (g_we) begin
        model_cmp(gt, dt);
      end else begin
        m_unx = 1;
        model_fail('0, dt);
      end
    end else if (g_we) begin
      if (m_q.size() == DEPTH) begin
        m_ovf = 1;
        model_fail(gt, '0);
      end else begin
        m_q.push_back(gt);
      end
    end
  endfunction

  always @(negedge CLK) begin
    if (chk_en) begin
      chk("level", 64'(level), 64'(m_q.size()));
      chk("match_cnt", 64'(match_cnt), 64'(m_mc));
      chk("mismatch_cnt", 64'(mismatch_cnt), 64'(m_mmc));
      chk("mismatch", 64'(mismatch), 64'(m_mm));
      chk("error", 64'(error), 64'(m_err));
      chk("overflow", 64'(overflow), 64'(m_ovf));
      chk("unexpected", 64'(unexpected), 64'(m_unx));
      chk("fail_exp", {22'd0, fail_exp_addr, fail_exp_data}, 64'(m_fexp));
      chk("fail_got", {22'd0, fail_got_addr, fail_got_data}, 64'(m_fgot));
      chk("drained", 64'(drained), 64'(m_q.size() == 0 && !m_err));
    end
  end

  // Called at posedge+1; returns at posedge+1 after the edge has taken effect.
  task automatic step(input logic gw, input logic [9:0] ga, input logic [31:0] gd,
                      input logic dw, input logic [9:0] da, input logic [31:0] dd,
                      input logic clr);
    g_we = gw; g_addr = ga; g_data = gd;
    d_we = dw; d_addr = da; d_data = dd;
    CLEAR = clr;
    @(negedge CLK); #1;
    model_update();
    @(posedge CLK); #1;
    g_we = 1'b0; d_we = 1'b0; CLEAR = 1'b0;
  endtask

  task automatic idle();  step(0, '0, '0, 0, '0, '0, 0); endtask
  task automatic clr();   step(0, '0, '0, 0, '0, '0, 1); endtask
  task automatic gst(input logic [9:0] a, input logic [31:0] d); step(1, a, d, 0, '0, '0, 0); endtask
  task automatic dst(input logic [9:0] a, input logic [31:0] d); step(0, '0, '0, 1, a, d, 0); endtask

  initial begin
    logic gw, dw;
    logic [9:0] ga;
    logic [31:0] gd;
    store_txn_t base;
    int pg, pd;

    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_level", 64'(level), 64'd0);
    chk("reset_drained", 64'(drained), 64'd1);
    RESET = 1'b0;
    chk_en = 1'b1;

    // 1: two buffered stores, matched 3 cycles later
    gst(10'h004, 32'hDEADBEEF);
    gst(10'h008, 32'h12345678);
    idle();
    dst(10'h004, 32'hDEADBEEF);
    dst(10'h008, 32'h12345678);
    chk("t1_match_cnt", 64'(match_cnt), 64'd2);
    chk("t1_mismatch_cnt", 64'(mismatch_cnt), 64'd0);
    chk("t1_drained", 64'(drained), 64'd1);
    clr();

    // 2: data mismatch
    gst(10'h010, 32'h1);
    dst(10'h010, 32'h2);
    chk("t2_mismatch_pulse", 64'(mismatch), 64'd1);
    chk("t2_fail_exp_data", 64'(fail_exp_data), 64'h1);
    chk("t2_fail_got_data", 64'(fail_got_data), 64'h2);
    idle();
    chk("t2_mismatch_low", 64'(mismatch), 64'd0);
    chk("t2_error", 64'(error), 64'd1);
    chk("t2_mismatch_cnt", 64'(mismatch_cnt), 64'd1);
    clr();

    // 3: same-cycle bypass on empty FIFO
    step(1, 10'h020, 32'hA5A5A5A5, 1, 10'h020, 32'hA5A5A5A5, 0);
    chk("t3_level", 64'(level), 64'd0);
    chk("t3_match_cnt", 64'(match_cnt), 64'd1);
    clr();

    // 4: fill, overflow, drain
    for (int i = 0; i < DEPTH; i++) gst(10'(i * 4), 32'hC000_0000 + 32'(i));
    chk("t4_level_full", 64'(level), 64'd16);
    gst(10'h3FC, 32'hFFFF0000);
    chk("t4_overflow", 64'(overflow), 64'd1);
    chk("t4_fail_exp_addr", 64'(fail_exp_addr), 64'h3FC);
    for (int i = 0; i < DEPTH; i++) dst(10'(i * 4), 32'hC000_0000 + 32'(i));
    chk("t4_match_cnt", 64'(match_cnt), 64'd16);
    chk("t4_level_empty", 64'(level), 64'd0);
    chk("t4_drained", 64'(drained), 64'd0);
    clr();

    // 5: unexpected DUV store
    dst(10'h030, 32'h5);
    chk("t5_unexpected", 64'(unexpected), 64'd1);
    chk("t5_fail_got_addr", 64'(fail_got_addr), 64'h030);
    chk("t5_fail_exp_addr", 64'(fail_exp_addr), 64'h0);
    chk("t5_counters", {32'd0, match_cnt, mismatch_cnt}, 64'd0);
    clr();

    // 6: async reset mid-stream, then synchronous clear
    for (int i = 0; i < 5; i++) gst(10'(i), 32'(i));
    gst(10'h3FF, 32'h0);
    dst(10'h001, 32'h1);
    chk("t6_level_pre", 64'(level), 64'd5);
    chk("t6_error_pre", 64'(error), 64'd1);
    RESET = 1'b1;
    model_reset();
    #1;
    chk("t6_rst_level", 64'(level), 64'd0);
    chk("t6_rst_flags", {60'd0, error, overflow, unexpected, mismatch}, 64'd0);
    chk("t6_rst_cnt", {32'd0, match_cnt, mismatch_cnt}, 64'd0);
    @(posedge CLK); #1;
    RESET = 1'b0;
    for (int i = 0; i < 5; i++) gst(10'(i), 32'(i));
    dst(10'h000, 32'h7);
    clr();
    chk("t6_clr_level", 64'(level), 64'd0);
    chk("t6_clr_error", 64'(error), 64'd0);
    chk("t6_clr_cnt", {32'd0, match_cnt, mismatch_cnt}, 64'd0);
    chk("t6_clr_fail", {22'd0, fail_exp_addr, fail_exp_data}, 64'd0);

    // Randomized traffic with three push/pop mixes
    for (int blk = 0; blk < 3; blk++) begin
      pg = (blk == 0) ? 50 : (blk == 1) ? 80 : 30;
      pd = (blk == 0) ? 45 : (blk == 1) ? 30 : 60;
      clr();
      for (int c = 0; c < 600; c++) begin
        gw = ($urandom_range(99) < pg);
        dw = ($urandom_range(99) < pd);
        ga = 10'($urandom);
        gd = $urandom;
        if (m_q.size() > 0)  base = m_q[0];
        else if (gw)         base = '{addr: ga, data: gd};
        else                 base = '{addr: 10'($urandom), data: $urandom};
        if ($urandom_range(9) == 0) base.data[$urandom_range(31)] ^= 1'b1;
        if ($urandom_range(19) == 0) base.addr[$urandom_range(9)] ^= 1'b1;
        step(gw, ga, gd, dw, base.addr, base.data, ($urandom_range(199) == 0));
      end
    end

    idle();
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
